// File: rtl/vec_accel_pkg.sv
// rtl/vec_accel_pkg.sv - shared serializer state type and word/byte constants
package vec_accel_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } out_ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock word FIFO with registered count and flags
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    // A push while full is dropped outright, even if a pop frees a slot this cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/output_blk.sv
// rtl/output_blk.sv - word FIFO plus little-endian byte serializer; OUTPUT_BLK_DROP_CNT_EN adds drop_count
module output_blk
    import vec_accel_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_output_blk,
    input  logic [WORD_W-1:0] data_in,
    output logic              output_blk_full,
    output logic              output_blk_empty,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
`ifdef OUTPUT_BLK_DROP_CNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    out_ser_state_t        state_q, state_d;
    logic [WORD_W-1:0]     shift_q, shift_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    logic                  fifo_pop;
    logic [WORD_W-1:0]     fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (set_output_blk),
        .pop_i   (fifo_pop),
        .wdata_i (data_in),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign output_blk_full  = fifo_full;
    assign output_blk_empty = (fifo_count == '0) && (state_q == IDLE);
    assign tx_valid         = (state_q == SEND);
    assign tx_data          = tx_valid ? shift_q[7:0] : 8'h00;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    idx_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // Chain straight into the next word so only the LOAD cycle separates words.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            state_d  = LOAD;
                        end else begin
                            shift_d  = '0;
                            state_d  = IDLE;
                        end
                    end else begin
                        shift_d = shift_q >> 8;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

`ifdef OUTPUT_BLK_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (set_output_blk && fifo_full && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: doc/output_blk.md
OUTPUT_BLK -- requirements
Module: output_blk

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit words; power of two, >= 2.
REQ-002 Parameter WORD_W, default 32, word width; fixed at 32, serialized as 4 bytes.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 set_output_blk  input  1  write strobe; each high cycle is one write request.
REQ-006 data_in  input  32  word sampled when set_output_blk is high.
REQ-007 output_blk_full  output  1  FIFO holds DEPTH words.
REQ-008 output_blk_empty  output  1  FIFO holds 0 words and serializer is idle.
REQ-009 tx_data  output  8  byte to host link.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  host link accepts the byte this cycle.
REQ-012 drop_count  output  16  rejected-write counter; present only with OUTPUT_BLK_DROP_CNT_EN.

Function
REQ-013 Write accepted iff set_output_blk=1 and output_blk_full=0 at that edge; the word enters the tail.
REQ-014 Write while full is discarded; FIFO contents are unchanged, even if a pop occurs in the same cycle.
REQ-015 Simultaneous accepted write and pop leave the count unchanged; pointers wrap modulo DEPTH.
REQ-016 Count width is clog2(DEPTH)+1; full = (count==DEPTH); both flags derive from registered count/state only.
REQ-017 Serializer FSM states: IDLE, LOAD, SEND.
REQ-018 IDLE: if FIFO is non-empty, pop the head into a 32-bit shift register, go to LOAD; else stay.
REQ-019 LOAD: byte index = 0, assert tx_valid next cycle, go to SEND.
REQ-020 SEND: tx_valid=1, tx_data=shift[7:0]; on tx_ready, shift right 8 and increment the index.
REQ-021 Byte order is little-endian: data_in[7:0] is sent first, data_in[31:24] last.
REQ-022 On acceptance of byte 3: if FIFO is non-empty, pop and go to LOAD; else go to IDLE with tx_valid=0.
REQ-023 tx_data and tx_valid are held stable while tx_valid=1 and tx_ready=0.
REQ-024 tx_ready is ignored when tx_valid=0.
REQ-025 Latency: a word written into an empty block at edge N produces tx_valid=1 after edge N+2.
REQ-026 Sustained throughput: one byte per cycle while tx_ready=1, with one LOAD bubble cycle per word.

Reset
REQ-027 While rst=1: pointers, count, shift register and index = 0; FSM = IDLE.
REQ-028 Reset output values: tx_valid=0, tx_data=0, output_blk_full=0, output_blk_empty=1, drop_count=0.
REQ-029 Reset mid-word abandons the partial word; no further bytes of it are sent after reset.

Configuration
REQ-030 Macro OUTPUT_BLK_DROP_CNT_EN defined: drop_count increments once per rejected write and saturates at 0xFFFF.
REQ-031 Macro OUTPUT_BLK_DROP_CNT_EN undefined: port drop_count and its counter logic are absent; behaviour is otherwise identical.

Structure
REQ-032 Shared package vec_accel_pkg holds out_ser_state_t (IDLE/LOAD/SEND) and BYTES_PER_WORD=4.
REQ-033 Storage is a sub-module sync_fifo (parameters DEPTH, WORD_W; push/pop/full/empty/count); output_blk holds the serializer FSM.

Verification
REQ-034 Write 0xA1B2C3D4 into the empty block with tx_ready=1 -> tx_valid rises 2 edges later; bytes D4,C3,B2,A1 are sent on consecutive cycles; empty=1 afterwards.
REQ-035 Write 3 words back-to-back with tx_ready=1 -> 12 bytes in order, exactly one bubble cycle between words.
REQ-036 tx_ready=0 for 5 cycles mid-word -> tx_data and tx_valid remain constant; the word resumes at the same byte.
REQ-037 tx_ready=0, write DEPTH+3 words -> full=1 after DEPTH writes, 3 writes dropped, drop_count=3 (with macro); draining yields exactly the first DEPTH words.
REQ-038 Write while full with a pop in the same cycle -> write rejected; count = DEPTH-1 after the edge.
REQ-039 Assert rst=1 for 1 cycle after byte 1 of a word -> tx_valid=0 the next cycle, empty=1, no remaining bytes emitted.
